// File: rtl/fetch_pkg.sv
// Shared fetch/decode definitions: datapath widths, the NOP encoding, the
// default reset PC, the fetch-to-decode payload and the instruction field
// slices that the decoder uses.
package fetch_pkg;

    localparam int unsigned PC_W   = 32;
    localparam int unsigned INST_W = 32;
    localparam int unsigned PERF_W = 32;

    localparam logic [INST_W-1:0] NOP_INST         = 32'h0000_0000;
    localparam logic [PC_W-1:0]   RESET_PC_DEFAULT = 32'h0000_0000;

    // Instruction field bit positions (msb/lsb)
    localparam int unsigned OPCODE_MSB = 31;
    localparam int unsigned OPCODE_LSB = 27;
    localparam int unsigned RD_MSB     = 26;
    localparam int unsigned RD_LSB     = 22;
    localparam int unsigned RS_MSB     = 21;
    localparam int unsigned RS_LSB     = 17;
    localparam int unsigned RT_MSB     = 16;
    localparam int unsigned RT_LSB     = 12;
    localparam int unsigned SHAMT_MSB  = 11;
    localparam int unsigned SHAMT_LSB  = 7;
    localparam int unsigned ALUOP_MSB  = 6;
    localparam int unsigned ALUOP_LSB  = 2;
    localparam int unsigned IMMED_MSB  = 16;
    localparam int unsigned IMMED_LSB  = 0;
    localparam int unsigned TARGET_MSB = 26;
    localparam int unsigned TARGET_LSB = 0;

    localparam int unsigned REG_W    = 5;
    localparam int unsigned IMMED_W  = IMMED_MSB - IMMED_LSB + 1;
    localparam int unsigned TARGET_W = TARGET_MSB - TARGET_LSB + 1;

    // Fetch-to-decode payload
    typedef struct packed {
        logic              valid;
        logic [INST_W-1:0] inst;
        logic [PC_W-1:0]   pc;
        logic [PC_W-1:0]   pc_plus1;
    } fd_bus_t;

    function automatic logic [REG_W-1:0] inst_opcode(input logic [INST_W-1:0] inst);
        return inst[OPCODE_MSB:OPCODE_LSB];
    endfunction

    function automatic logic [REG_W-1:0] inst_rd(input logic [INST_W-1:0] inst);
        return inst[RD_MSB:RD_LSB];
    endfunction

    function automatic logic [REG_W-1:0] inst_rs(input logic [INST_W-1:0] inst);
        return inst[RS_MSB:RS_LSB];
    endfunction

    function automatic logic [REG_W-1:0] inst_rt(input logic [INST_W-1:0] inst);
        return inst[RT_MSB:RT_LSB];
    endfunction

    function automatic logic [REG_W-1:0] inst_shamt(input logic [INST_W-1:0] inst);
        return inst[SHAMT_MSB:SHAMT_LSB];
    endfunction

    function automatic logic [REG_W-1:0] inst_aluop(input logic [INST_W-1:0] inst);
        return inst[ALUOP_MSB:ALUOP_LSB];
    endfunction

    function automatic logic [IMMED_W-1:0] inst_immed(input logic [INST_W-1:0] inst);
        return inst[IMMED_MSB:IMMED_LSB];
    endfunction

    function automatic logic [TARGET_W-1:0] inst_target(input logic [INST_W-1:0] inst);
        return inst[TARGET_MSB:TARGET_LSB];
    endfunction

endpackage

// File: rtl/fetch_perf_ctr.sv
// Single-event wrapping counter used for fetch performance statistics.
// Ports:
//   clock    - clock, rising edge
//   reset    - synchronous active-high clear
//   event_i  - count enable, one increment per cycle it is high
//   count_o  - current count (reflects events up to the previous cycle)
module fetch_perf_ctr
    import fetch_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              event_i,
    output logic [PERF_W-1:0] count_o
);

    logic [PERF_W-1:0] count_q;
    logic [PERF_W-1:0] count_d;

    // Next count: wraps naturally at 2^PERF_W
    always_comb begin
        count_d = count_q;
        if (event_i) begin
            count_d = count_q + PERF_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage feeding the decoder. Holds the PC, drives a
// synchronous-read instruction memory and presents {inst, pc, pc+1} under a
// valid/ready handshake. Downstream redirects squash the presented word.
// The instruction memory output itself acts as the pipeline register, so the
// only local state is the last issued address and its valid bit.
//
// Optional feature macro: FETCH_PERF_EN adds perf_fetched/perf_stall/
// perf_redirect wrapping event counters.
//
// Ports:
//   clock, reset    - clock and synchronous active-high reset
//   fetch_en        - 1 allows fetching, 0 idles the stage
//   imem_addr       - word address to imem (combinational from next-PC mux)
//   imem_data       - imem read data, valid the cycle after imem_addr
//   dec_ready       - decoder accepts fd_* this cycle
//   redirect_valid  - taken branch/jump; squash and refetch at redirect_pc
//   redirect_pc     - redirect target (word address)
//   fd_valid        - fd_* carry a real instruction
//   fd_inst         - instruction, NOP when fd_valid is low
//   fd_pc           - PC of fd_inst
//   fd_pc_plus1     - fd_pc + 1 (wraps at 32 bits)
//   perf_*          - event counters (FETCH_PERF_EN only)
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int unsigned      ADDR_W   = 12,
    parameter logic [PC_W-1:0]  RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                fetch_en,
    output logic [ADDR_W-1:0]   imem_addr,
    input  logic [INST_W-1:0]   imem_data,
    input  logic                dec_ready,
    input  logic                redirect_valid,
    input  logic [PC_W-1:0]     redirect_pc,
    output logic                fd_valid,
    output logic [INST_W-1:0]   fd_inst,
    output logic [PC_W-1:0]     fd_pc,
    output logic [PC_W-1:0]     fd_pc_plus1
`ifdef FETCH_PERF_EN
    ,
    output logic [PERF_W-1:0]   perf_fetched,
    output logic [PERF_W-1:0]   perf_stall,
    output logic [PERF_W-1:0]   perf_redirect
`endif
);

    logic [PC_W-1:0] a_q;
    logic [PC_W-1:0] a_d;
    logic            v_q;
    logic            v_d;
    logic            transfer;
    logic            stall;
    fd_bus_t         fd_bus;

    assign transfer = v_q & dec_ready;
    assign stall    = v_q & ~dec_ready;

    // Next-address priority: reset > redirect > stall > advance/hold.
    // A stall keeps v high even with fetch_en low so the word is not lost.
    always_comb begin
        a_d = a_q;
        v_d = fetch_en;
        if (reset) begin
            a_d = RESET_PC;
            v_d = 1'b0;
        end else if (redirect_valid) begin
            a_d = redirect_pc;
            v_d = fetch_en;
        end else if (stall) begin
            a_d = a_q;
            v_d = 1'b1;
        end else if (transfer) begin
            a_d = a_q + PC_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            a_q <= RESET_PC;
            v_q <= 1'b0;
        end else begin
            a_q <= a_d;
            v_q <= v_d;
        end
    end

    // imem aliases modulo 2^ADDR_W; upper PC bits are not checked
    assign imem_addr = a_d[ADDR_W-1:0];

    always_comb begin
        fd_bus.valid    = v_q;
        fd_bus.inst     = v_q ? imem_data : NOP_INST;
        fd_bus.pc       = a_q;
        fd_bus.pc_plus1 = a_q + PC_W'(1);
    end

    assign fd_valid    = fd_bus.valid;
    assign fd_inst     = fd_bus.inst;
    assign fd_pc       = fd_bus.pc;
    assign fd_pc_plus1 = fd_bus.pc_plus1;

`ifdef FETCH_PERF_EN
    fetch_perf_ctr u_perf_fetched (
        .clock   (clock),
        .reset   (reset),
        .event_i (transfer),
        .count_o (perf_fetched)
    );

    fetch_perf_ctr u_perf_stall (
        .clock   (clock),
        .reset   (reset),
        .event_i (stall),
        .count_o (perf_stall)
    );

    fetch_perf_ctr u_perf_redirect (
        .clock   (clock),
        .reset   (reset),
        .event_i (redirect_valid),
        .count_o (perf_redirect)
    );
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: the driver applies one cycle of inputs
// and queues the hand-computed expected outputs for that cycle; the monitor
// pops and compares on the falling edge.
module tb_fetch_stage;

    logic        clock;
    logic        reset;
    logic        fetch_en;
    logic [11:0] imem_addr;
    logic [31:0] imem_data;
    logic        dec_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fd_valid;
    logic [31:0] fd_inst;
    logic [31:0] fd_pc;
    logic [31:0] fd_pc_plus1;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall;
    logic [31:0] perf_redirect;
`endif

    fetch_stage #(.ADDR_W(12), .RESET_PC(32'h0000_0000)) dut (
        .clock          (clock),
        .reset          (reset),
        .fetch_en       (fetch_en),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .dec_ready      (dec_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fd_valid       (fd_valid),
        .fd_inst        (fd_inst),
        .fd_pc          (fd_pc),
        .fd_pc_plus1    (fd_pc_plus1)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_stall     (perf_stall),
        .perf_redirect  (perf_redirect)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Synchronous-read instruction memory model
    logic [31:0] mem [0:4095];
    always @(posedge clock) imem_data <= mem[imem_addr];

    typedef struct {
        int          id;
        logic        v;
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] plus1;
        logic [11:0] addr;
        logic        pchk;
        logic [31:0] pf;
        logic [31:0] ps;
        logic [31:0] pr;
    } exp_t;

    exp_t expq[$];
    int   n_assert = 0;
    int   n_fail   = 0;
    int   cyc_id   = 0;

    logic        p_chk = 1'b0;
    logic [31:0] p_f   = '0;
    logic [31:0] p_s   = '0;
    logic [31:0] p_r   = '0;

    task automatic chk(input int id, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL cyc%0d %s: got %h expected %h", id, name, act, exp);
        end
    endtask

    // Monitor: one expected record per cycle, compared mid-cycle
    always @(negedge clock) begin
        if (expq.size() > 0) begin
            exp_t e;
            e = expq.pop_front();
            chk(e.id, "fd_valid", {31'b0, fd_valid}, {31'b0, e.v});
            chk(e.id, "fd_pc", fd_pc, e.pc);
            chk(e.id, "fd_inst", fd_inst, e.inst);
            chk(e.id, "fd_pc_plus1", fd_pc_plus1, e.plus1);
            chk(e.id, "imem_addr", {20'b0, imem_addr}, {20'b0, e.addr});
`ifdef FETCH_PERF_EN
            if (e.pchk) begin
                chk(e.id, "perf_fetched", perf_fetched, e.pf);
                chk(e.id, "perf_stall", perf_stall, e.ps);
                chk(e.id, "perf_redirect", perf_redirect, e.pr);
            end
`endif
        end
    end

    // Drive one cycle of inputs and queue that cycle's expected outputs
    task automatic cyc(input logic rst, input logic fe, input logic rdy, input logic rv,
                       input logic [31:0] rpc, input logic ev, input logic [31:0] epc,
                       input logic [11:0] eaddr);
        exp_t e;
        reset          = rst;
        fetch_en       = fe;
        dec_ready      = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        e.id    = cyc_id;
        e.v     = ev;
        e.pc    = epc;
        e.inst  = ev ? mem[epc[11:0]] : 32'h0;
        e.plus1 = epc + 32'd1;
        e.addr  = eaddr;
        e.pchk  = p_chk;
        e.pf    = p_f;
        e.ps    = p_s;
        e.pr    = p_r;
        expq.push_back(e);
        p_chk = 1'b0;
        cyc_id++;
        @(posedge clock);
        #1;
    endtask

    task automatic perf_exp(input logic [31:0] f, input logic [31:0] s, input logic [31:0] r);
        p_chk = 1'b1;
        p_f   = f;
        p_s   = s;
        p_r   = r;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 32'h5A00_0000 | i;
        mem[0] = 32'hFAEBCDEF;
        mem[1] = 32'hABCDEFFF;
        mem[2] = 32'h12345678;
        mem[3] = 32'h89ABCDEF;

        reset = 1'b1; fetch_en = 1'b0; dec_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = '0;
        repeat (2) @(posedge clock);
        #1;

        //  rst  fe   rdy  rv   rpc            v    pc             addr
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        12'h000); // c0 reset state
        perf_exp(0, 0, 0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        12'h000); // c1 reset released
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'h0,        12'h001); // c2 pc0
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'h1,        12'h002); // c3 pc1
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'h2,        12'h002); // c4 stall
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'h2,        12'h002); // c5 stall
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'h2,        12'h002); // c6 stall
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'h2,        12'h003); // c7 release
        perf_exp(3, 3, 0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'h3,        12'h004); // c8 pc3
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'h4,        12'h005); // c9 pc4
        perf_exp(5, 3, 0);
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 32'h40,       1'b1, 32'h5,        12'h040); // c10 redirect while stalled
        perf_exp(5, 4, 1);
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 32'h6,        1'b1, 32'h40,       12'h006); // c11 redirect drops ready word
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'h6,        12'h007); // c12 pc6
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'h7,        12'h008); // c13 pc7 transfers, fetch off
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h8,        12'h008); // c14 idle
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h8,        12'h008); // c15 idle holds
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h8,        12'h008); // c16 re-enable
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'h8,        12'h009); // c17 pc8
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'h9,        12'h009); // c18 stall pc9
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'h9,        12'h000); // c19 reset during stall
        perf_exp(0, 0, 0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        12'h000); // c20 cleared
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1, 32'h0,       12'hFFF); // c21 redirect to max
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'hFFFF_FFFF, 12'h000); // c22 wrap
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'h0,        12'h001); // c23 pc0 after wrap

        @(negedge clock);
        n_assert++;
        if (expq.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", expq.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
